seg7_scan_driver: RTL and testbench

- Multiplexed seven-segment display driver for the vending machine front panel.
- Consumes the toggling `slow_clock` output of the 1 kHz clock divider as a refresh timebase.
- Synchronises and edge-detects `slow_clock` inside the system clock domain; it is never used as a clock.
- Steps through NUM_DIGITS BCD digits, one per refresh tick, and drives one-hot anodes plus segment lines from a frame-stable snapshot of the inputs.

---
 rtl/seg7_pkg.sv | 20 ++
 rtl/bcd_to_seg7.sv | 27 ++
 rtl/seg7_scan_driver.sv | 129 ++++++++++++
 tb/tb_seg7_scan_driver.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared seven-segment glyph constants, {g,f,e,d,c,b,a} order, active-high.
// Used by the scan driver and any future message or price display blocks.
package seg7_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_0     = 7'h3F;
  localparam seg7_t SEG_1     = 7'h06;
  localparam seg7_t SEG_2     = 7'h5B;
  localparam seg7_t SEG_3     = 7'h4F;
  localparam seg7_t SEG_4     = 7'h66;
  localparam seg7_t SEG_5     = 7'h6D;
  localparam seg7_t SEG_6     = 7'h7D;
  localparam seg7_t SEG_7     = 7'h07;
  localparam seg7_t SEG_8     = 7'h7F;
  localparam seg7_t SEG_9     = 7'h6F;
  localparam seg7_t SEG_DASH  = 7'h40;
  localparam seg7_t SEG_BLANK = 7'h00;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to seven-segment decoder, active-high.
// Non-BCD codes show a dash so corrupted data is visible on the panel.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment scan driver; slow_clock is sampled as data and
// each of its edges advances the display by one digit.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int ACTIVE_LOW_SEG = 1,
  parameter int ACTIVE_LOW_AN  = 1,
  parameter int BLANK_LEADING  = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    slow_clock,
  input  logic [4*NUM_DIGITS-1:0] digits_bcd,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_done
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF = (ACTIVE_LOW_AN != 0) ? '1 : '0;
  localparam logic [6:0] SEG_OFF = (ACTIVE_LOW_SEG != 0) ? 7'h7F : 7'h00;
  localparam logic DP_OFF = (ACTIVE_LOW_SEG != 0);

  logic [2:0]              sync_q, sync_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] shadow_bcd_q, shadow_bcd_d;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic                    frame_done_q, frame_done_d;

  logic                    tick;
  logic [4*NUM_DIGITS-1:0] frame_bcd;
  logic [NUM_DIGITS-1:0]   frame_dp;
  logic [3:0]              frame_dig [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   zero_above;
  logic                    zero_run;
  logic [3:0]              cur_bcd;
  logic [6:0]              dec_seg;
  logic [6:0]              seg_act;
  logic                    blank;
  logic [NUM_DIGITS-1:0]   an_onehot;

  // sync_q[0..1] synchronise, sync_q[2] is the previous sample for edge detect
  assign tick = sync_q[1] ^ sync_q[2];

  // On the frame-start tick the live inputs are shown so a new frame appears at once
  always_comb begin
    frame_bcd = (idx_q == '0) ? digits_bcd : shadow_bcd_q;
    frame_dp  = (idx_q == '0) ? dp_in      : shadow_dp_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      frame_dig[i] = frame_bcd[4*i +: 4];
    end
  end

  always_comb begin
    zero_run   = 1'b1;
    zero_above = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run      = zero_run & (frame_dig[k] == 4'd0);
      zero_above[k] = zero_run;
    end
  end

  assign cur_bcd   = frame_dig[idx_q];
  assign blank     = (BLANK_LEADING != 0) && (idx_q != '0) && zero_above[idx_q];
  assign seg_act   = blank ? SEG_BLANK : dec_seg;
  assign an_onehot = NUM_DIGITS'(1) << idx_q;

  bcd_to_seg7 u_dec (
    .bcd (cur_bcd),
    .seg (dec_seg)
  );

  always_comb begin
    sync_d       = {sync_q[1:0], slow_clock};
    idx_d        = idx_q;
    shadow_bcd_d = shadow_bcd_q;
    shadow_dp_d  = shadow_dp_q;
    an_d         = an_q;
    seg_d        = seg_q;
    dp_d         = dp_q;
    frame_done_d = 1'b0;
    if (tick) begin
      if (idx_q == '0) begin
        shadow_bcd_d = digits_bcd;
        shadow_dp_d  = dp_in;
      end
      an_d         = an_onehot ^ AN_OFF;
      seg_d        = seg_act ^ SEG_OFF;
      dp_d         = frame_dp[idx_q] ^ DP_OFF;
      frame_done_d = (idx_q == IDX_LAST);
      idx_d        = (idx_q >= IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q       <= '0;
      idx_q        <= '0;
      shadow_bcd_q <= '0;
      shadow_dp_q  <= '0;
      an_q         <= AN_OFF;
      seg_q        <= SEG_OFF;
      dp_q         <= DP_OFF;
      frame_done_q <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      idx_q        <= idx_d;
      shadow_bcd_q <= shadow_bcd_d;
      shadow_dp_q  <= shadow_dp_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver with default parameters (4 digits, active-low).
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        slow_clock = 1'b0;
  logic [15:0] digits_bcd = 16'h0000;
  logic [3:0]  dp_in = 4'b0000;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   failures = 0;
  int   cyc = 0;
  int   fd_count = 0;
  logic [3:0] prev_an = 4'hF;

  // active-low glyphs
  localparam logic [6:0] G0 = 7'h40, G1 = 7'h79, G2 = 7'h24, G3 = 7'h30, G4 = 7'h19;
  localparam logic [6:0] G5 = 7'h12, G9 = 7'h10, GBL = 7'h7F, GDASH = 7'h3F;

  seg7_scan_driver dut (
    .clk        (clk),
    .reset      (reset),
    .slow_clock (slow_clock),
    .digits_bcd (digits_bcd),
    .dp_in      (dp_in),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic chk_off(input string name);
    chk({name, "_an"}, 32'(an), 32'hF);
    chk({name, "_seg"}, 32'(seg), 32'h7F);
    chk({name, "_dp"}, 32'(dp), 32'h1);
    chk({name, "_fd"}, 32'(frame_done), 32'h0);
  endtask

  // Called at a negedge: queue the expected result, then toggle slow_clock
  task automatic do_tick(input logic [3:0] ean, input logic [6:0] eseg,
                         input logic edp, input logic efd);
    exp_t e;
    e.an  = ean;
    e.seg = eseg;
    e.dp  = edp;
    e.fd  = efd;
    e.cyc = cyc + 3;
    exp_q.push_back(e);
    slow_clock = ~slow_clock;
    repeat (6) @(negedge clk);
  endtask

  // Monitor: every tick moves the one-hot anode, so an anode change marks a new output
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_an = an;
      end else begin
        if (frame_done === 1'b1) fd_count++;
        if (an !== prev_an) begin
          prev_an = an;
          if (exp_q.size() == 0) begin
            chk("unexpected_update", {19'd0, an, seg, dp, frame_done}, 32'hFFFF_FFFF);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("tick_outputs", {19'd0, an, seg, dp, frame_done},
                {19'd0, e.an, e.seg, e.dp, e.fd});
            chk("tick_latency", 32'(cyc), 32'(e.cyc));
          end
        end
      end
    end
  end

  initial begin
    repeat (5) @(negedge clk);
    chk_off("reset_held");
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk_off("reset_released");
    repeat (1000) @(negedge clk);
    chk_off("static_hold");

    digits_bcd = 16'h1234;
    dp_in      = 4'b0100;
    do_tick(4'b1110, G4, 1'b1, 1'b0);
    do_tick(4'b1101, G3, 1'b1, 1'b0);
    do_tick(4'b1011, G2, 1'b0, 1'b0);
    do_tick(4'b0111, G1, 1'b1, 1'b1);

    dp_in      = 4'b0000;
    digits_bcd = 16'h0042;
    do_tick(4'b1110, G2, 1'b1, 1'b0);
    do_tick(4'b1101, G4, 1'b1, 1'b0);
    do_tick(4'b1011, GBL, 1'b1, 1'b0);
    do_tick(4'b0111, GBL, 1'b1, 1'b1);
    digits_bcd = 16'h0000;
    do_tick(4'b1110, G0, 1'b1, 1'b0);
    do_tick(4'b1101, GBL, 1'b1, 1'b0);
    do_tick(4'b1011, GBL, 1'b1, 1'b0);
    do_tick(4'b0111, GBL, 1'b1, 1'b1);

    digits_bcd = 16'h00A5;
    do_tick(4'b1110, G5, 1'b1, 1'b0);
    do_tick(4'b1101, GDASH, 1'b1, 1'b0);
    do_tick(4'b1011, GBL, 1'b1, 1'b0);
    do_tick(4'b0111, GBL, 1'b1, 1'b1);

    digits_bcd = 16'h1111;
    do_tick(4'b1110, G1, 1'b1, 1'b0);
    do_tick(4'b1101, G1, 1'b1, 1'b0);
    digits_bcd = 16'h2222;
    do_tick(4'b1011, G1, 1'b1, 1'b0);
    do_tick(4'b0111, G1, 1'b1, 1'b1);
    do_tick(4'b1110, G2, 1'b1, 1'b0);
    do_tick(4'b1101, G2, 1'b1, 1'b0);
    do_tick(4'b1011, G2, 1'b1, 1'b0);
    do_tick(4'b0111, G2, 1'b1, 1'b1);

    digits_bcd = 16'h5555;
    do_tick(4'b1110, G5, 1'b1, 1'b0);
    do_tick(4'b1101, G5, 1'b1, 1'b0);
    #2 reset = 1'b0;
    #1 chk_off("midframe_reset");
    digits_bcd = 16'h0009;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    do_tick(4'b1110, G9, 1'b1, 1'b0);
    do_tick(4'b1101, GBL, 1'b1, 1'b0);

    repeat (10) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("frame_done_pulses", 32'(fd_count), 32'd6);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
